apb3_fabric_wdg: RTL and testbench

Parametrised APB3 interconnect that fans one APB3 master out to up to 16 slaves. It sits between the AHB-to-APB bridge and the peripheral slots, like the fixed five-slot APB3 interconnect it supersedes. Beyond slot decoding and response muxing, it tracks the APB phase in a state machine and adds a per-transfer PREADY watchdog. Unmapped-slot accesses complete with an error, and a sticky error-capture register reports faults to software via an interrupt.

---
 rtl/apb3_fabric_pkg.sv | 18 +
 rtl/apb3_wdg_counter.sv | 38 +++
 rtl/apb3_fabric_wdg.sv | 195 +++++++++++++++++++
 tb/tb_apb3_fabric_wdg.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_fabric_pkg.sv
// Shared types and constants for the APB3 fabric with PREADY watchdog.
package apb3_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_TOUT   = 2'b11
    } apb_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DECODE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int SLOT_W   = 4;
    localparam int SLOT_MAX = 16;

endpackage

// File: rtl/apb3_wdg_counter.sv
// Per-transfer slave wait counter with saturating count and expiry compare.
module apb3_wdg_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] W_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] W_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [CW-1:0] r_wait_cnt;

    // Wait-cycle count: cleared at SETUP, saturates at TIMEOUT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_wait_cnt <= {CW{1'b0}};
        end else if (i_inc && (r_wait_cnt != W_MAX)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1'b1);
        end
    end

    // Expiry fires on the wait cycle that brings the count to TIMEOUT.
    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            assign o_expire = i_inc && (r_wait_cnt == W_LAST);
        end
    endgenerate

endmodule

// File: rtl/apb3_fabric_wdg.sv
// APB3 1:N interconnect: slot decode, response mux, PREADY watchdog and
// sticky error capture with interrupt.
module apb3_fabric_wdg
    import apb3_fabric_pkg::*;
#(
    parameter int NUM_SLAVES = 5,
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int SLOT_LSB   = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESETN,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [AWIDTH-1:0]            PADDR,
    input  logic [DWIDTH-1:0]            PWDATA,
    output logic [DWIDTH-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_SLAVES-1:0]        PSELS,
    output logic [AWIDTH-1:0]            PADDRS,
    output logic [DWIDTH-1:0]            PWDATAS,
    output logic                         PENABLES,
    output logic                         PWRITES,
    input  logic [NUM_SLAVES*DWIDTH-1:0] PRDATAS,
    input  logic [NUM_SLAVES-1:0]        PREADYS,
    input  logic [NUM_SLAVES-1:0]        PSLVERRS,
    input  logic                         ERR_CLR,
    output logic                         ERR_VALID,
    output logic                         ERR_OVF,
    output logic [1:0]                   ERR_CAUSE,
    output logic [AWIDTH-1:0]            ERR_ADDR
);

    localparam logic [SLOT_W:0] NUM_SLV_W = (SLOT_W + 1)'(NUM_SLAVES);

    apb_state_e         r_state;
    apb_state_e         w_phase;
    logic [SLOT_W-1:0]  r_slot_q;
    logic [SLOT_W-1:0]  w_live_slot;
    logic [SLOT_W-1:0]  w_cur_slot;
    logic               w_mapped;
    logic [SLOT_MAX-1:0] w_preadys16;
    logic [SLOT_MAX-1:0] w_pslverrs16;
    logic [DWIDTH-1:0]  w_rdata16 [SLOT_MAX];
    logic               w_wait_inc;
    logic               w_access_done;
    logic               w_expire;
    logic               w_dec_err;
    logic               w_err;
    logic [1:0]         w_err_cause;
    logic               r_err_valid;
    logic               r_err_ovf;
    logic [1:0]         r_err_cause;
    logic [AWIDTH-1:0]  r_err_addr;

    // Pad slave responses to 16 slots so the 4-bit index never goes out of range.
    generate
        for (genvar n = 0; n < SLOT_MAX; n++) begin : g_pad
            if (n < NUM_SLAVES) begin : g_map
                assign w_preadys16[n]  = PREADYS[n];
                assign w_pslverrs16[n] = PSLVERRS[n];
                assign w_rdata16[n]    = PRDATAS[n*DWIDTH +: DWIDTH];
            end else begin : g_unmap
                assign w_preadys16[n]  = 1'b0;
                assign w_pslverrs16[n] = 1'b0;
                assign w_rdata16[n]    = {DWIDTH{1'b0}};
            end
        end
    endgenerate

    assign PADDRS   = PADDR;
    assign PWDATAS  = PWDATA;
    assign PENABLES = PENABLE;
    assign PWRITES  = PWRITE;

    assign w_live_slot = PADDR[SLOT_LSB +: SLOT_W];

    // Bus phase of the current cycle: a registered IDLE with PSEL high is the SETUP cycle.
    always_comb begin
        w_phase = ST_IDLE;
        if (!PRESETN || !PSEL) begin
            w_phase = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_phase = ST_SETUP;
        end else begin
            w_phase = r_state;
        end
    end

    assign w_cur_slot    = (w_phase == ST_SETUP) ? w_live_slot : r_slot_q;
    assign w_mapped      = ({1'b0, w_cur_slot} < NUM_SLV_W);
    assign w_wait_inc    = (w_phase == ST_ACCESS) && w_mapped && !w_preadys16[w_cur_slot];
    assign w_access_done = (w_phase == ST_ACCESS) && (!w_mapped || w_preadys16[w_cur_slot]);

    apb3_wdg_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wdg (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETN),
        .i_clr    (w_phase == ST_SETUP),
        .i_inc    (w_wait_inc),
        .o_expire (w_expire)
    );

    // Slave selects and response mux; unmapped slots and TOUT answer from the fabric.
    always_comb begin
        PSELS     = {NUM_SLAVES{1'b0}};
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = {DWIDTH{1'b0}};
        w_dec_err = 1'b0;
        case (w_phase)
            ST_SETUP, ST_ACCESS: begin
                if (w_mapped) begin
                    for (int n = 0; n < NUM_SLAVES; n++) begin
                        PSELS[n] = (w_cur_slot == SLOT_W'(n));
                    end
                    PREADY  = w_preadys16[w_cur_slot];
                    PSLVERR = w_pslverrs16[w_cur_slot];
                    PRDATA  = w_rdata16[w_cur_slot];
                end else begin
                    PSLVERR   = (w_phase == ST_ACCESS);
                    w_dec_err = (w_phase == ST_ACCESS);
                end
            end
            ST_TOUT: begin
                PSLVERR = 1'b1;
            end
            default: begin
                PREADY = 1'b1;
            end
        endcase
    end

    assign w_err       = w_dec_err || (w_phase == ST_TOUT);
    assign w_err_cause = (w_phase == ST_TOUT) ? ERR_TIMEOUT : ERR_DECODE;

    // Phase FSM and slot latch.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state  <= ST_IDLE;
            r_slot_q <= {SLOT_W{1'b0}};
        end else begin
            if (w_phase == ST_SETUP) begin
                r_slot_q <= w_live_slot;
            end
            case (w_phase)
                ST_SETUP:  r_state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (w_expire) begin
                        r_state <= ST_TOUT;
                    end else if (w_access_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_TOUT:   r_state <= ST_IDLE;
                ST_IDLE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error capture; a new error beats a simultaneous clear.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_err_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_err_addr  <= {AWIDTH{1'b0}};
        end else if (w_err) begin
            if (!r_err_valid || ERR_CLR) begin
                r_err_valid <= 1'b1;
                r_err_ovf   <= 1'b0;
                r_err_cause <= w_err_cause;
                r_err_addr  <= PADDR;
            end else begin
                r_err_ovf   <= 1'b1;
            end
        end else if (ERR_CLR) begin
            r_err_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
        end
    end

    assign ERR_VALID = r_err_valid;
    assign ERR_OVF   = r_err_ovf;
    assign ERR_CAUSE = r_err_cause;
    assign ERR_ADDR  = r_err_addr;

endmodule

// File: tb/tb_apb3_fabric_wdg.sv
// Scoreboard bench for apb3_fabric_wdg: expectations are queued per cycle and drained at the falling edge.
module tb_apb3_fabric_wdg;

    localparam int NS = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic              PCLK = 1'b0;
    logic              PRESETN;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY, PSLVERR;
    logic [NS-1:0]     PSELS;
    logic [AW-1:0]     PADDRS;
    logic [DW-1:0]     PWDATAS;
    logic              PENABLES, PWRITES;
    logic [NS*DW-1:0]  PRDATAS;
    logic [NS-1:0]     PREADYS, PSLVERRS;
    logic              ERR_CLR;
    logic              ERR_VALID, ERR_OVF;
    logic [1:0]        ERR_CAUSE;
    logic [AW-1:0]     ERR_ADDR;

    always #5 PCLK = ~PCLK;

    apb3_fabric_wdg #(
        .NUM_SLAVES (NS),
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .SLOT_LSB   (12),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .PSELS     (PSELS),
        .PADDRS    (PADDRS),
        .PWDATAS   (PWDATAS),
        .PENABLES  (PENABLES),
        .PWRITES   (PWRITES),
        .PRDATAS   (PRDATAS),
        .PREADYS   (PREADYS),
        .PSLVERRS  (PSLVERRS),
        .ERR_CLR   (ERR_CLR),
        .ERR_VALID (ERR_VALID),
        .ERR_OVF   (ERR_OVF),
        .ERR_CAUSE (ERR_CAUSE),
        .ERR_ADDR  (ERR_ADDR)
    );

    typedef enum int {S_PSELS, S_PREADY, S_PSLVERR, S_PRDATA, S_PWDATAS,
                      S_EVALID, S_EOVF, S_ECAUSE, S_EADDR} sig_e;
    typedef struct {
        sig_e        sig;
        logic [63:0] val;
    } exp_t;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] rd [NS];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic sb_push(input sig_e s, input logic [63:0] v);
        exp_t e;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    function automatic logic [63:0] observe(input sig_e s);
        case (s)
            S_PSELS:   return 64'(PSELS);
            S_PREADY:  return 64'(PREADY);
            S_PSLVERR: return 64'(PSLVERR);
            S_PRDATA:  return 64'(PRDATA);
            S_PWDATAS: return 64'(PWDATAS);
            S_EVALID:  return 64'(ERR_VALID);
            S_EOVF:    return 64'(ERR_OVF);
            S_ECAUSE:  return 64'(ERR_CAUSE);
            S_EADDR:   return 64'(ERR_ADDR);
            default:   return {64{1'b1}};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.sig.name(), observe(e.sig), e.val);
        end
    endtask

    // Sample at the falling edge, then return to just after the next rising edge.
    task automatic cyc();
        @(negedge PCLK);
        drain();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic en, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [NS-1:0] rdy, input logic [NS-1:0] serr, input logic clr);
        PSEL     = sel;
        PENABLE  = en;
        PWRITE   = wr;
        PADDR    = addr;
        PWDATA   = wdata;
        PREADYS  = rdy;
        PSLVERRS = serr;
        ERR_CLR  = clr;
    endtask

    task automatic exp_err(input logic v, input logic o, input logic [1:0] c, input logic [AW-1:0] a);
        sb_push(S_EVALID, 64'(v));
        sb_push(S_EOVF,   64'(o));
        sb_push(S_ECAUSE, 64'(c));
        sb_push(S_EADDR,  64'(a));
    endtask

    task automatic exp_resp(input logic [NS-1:0] sels, input logic rdy, input logic serr, input logic [DW-1:0] data);
        sb_push(S_PSELS,   64'(sels));
        sb_push(S_PREADY,  64'(rdy));
        sb_push(S_PSLVERR, 64'(serr));
        sb_push(S_PRDATA,  64'(data));
    endtask

    initial begin
        PRESETN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        for (int n = 0; n < NS; n++) begin
            rd[n] = 32'h1111_1111 * (n + 1);
            PRDATAS[n*DW +: DW] = rd[n];
        end
        @(posedge PCLK);
        #1;

        // Reset state
        exp_resp(5'b00000, 1'b1, 1'b0, 32'h0);
        exp_err(1'b0, 1'b0, 2'b00, 32'h0);
        cyc();
        PRESETN = 1'b1;
        exp_resp(5'b00000, 1'b1, 1'b0, 32'h0);
        cyc();

        // Zero-wait write to slot 3
        drive(1'b1, 1'b0, 1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 5'b01000, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b01000));
        sb_push(S_PWDATAS, 64'(32'hDEAD_BEEF));
        cyc();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_3004, 32'hDEAD_BEEF, 5'b01000, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b01000));
        sb_push(S_PREADY, 64'(1'b1));
        sb_push(S_PSLVERR, 64'(1'b0));
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_resp(5'b00000, 1'b1, 1'b0, 32'h0);
        exp_err(1'b0, 1'b0, 2'b00, 32'h0);
        cyc();

        // Read slot 2 with data, then slot 4 with a slave-reported error
        drive(1'b1, 1'b0, 1'b0, 32'h0000_2010, 32'h0, 5'b00100, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b00100));
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_2010, 32'h0, 5'b00100, 5'b00000, 1'b0);
        exp_resp(5'b00100, 1'b1, 1'b0, rd[2]);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h55, 5'b10000, 5'b10000, 1'b0);
        sb_push(S_PSELS, 64'(5'b10000));
        cyc();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h55, 5'b10000, 5'b10000, 1'b0);
        exp_resp(5'b10000, 1'b1, 1'b1, rd[4]);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b0, 1'b0, 2'b00, 32'h0);
        cyc();

        // Unmapped slot 7 read: fabric error response and decode capture
        drive(1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0, 5'b11111, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b00000));
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 5'b11111, 5'b00000, 1'b0);
        exp_resp(5'b00000, 1'b1, 1'b1, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b1, 1'b0, 2'b01, 32'h0000_7000);
        cyc();

        // Second decode error while valid sets overflow, keeps first capture
        drive(1'b1, 1'b0, 1'b0, 32'h0000_9000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_resp(5'b00000, 1'b1, 1'b1, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b1);
        exp_err(1'b1, 1'b1, 2'b01, 32'h0000_7000);
        cyc();
        // Clear alone: flags drop, cause and address retained
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b0, 1'b0, 2'b01, 32'h0000_7000);
        cyc();

        // Watchdog: slot 1 stalls for TO access cycles, then TOUT
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b00010));
        cyc();
        for (int k = 0; k < TO; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 5'b00000, 5'b00000, 1'b0);
            sb_push(S_PSELS, 64'(5'b00010));
            sb_push(S_PREADY, 64'(1'b0));
            cyc();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 5'b00010, 5'b00000, 1'b0);
        exp_resp(5'b00000, 1'b1, 1'b1, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_resp(5'b00000, 1'b1, 1'b0, 32'h0);
        exp_err(1'b1, 1'b0, 2'b10, 32'h0000_1000);
        cyc();

        // Decode error coinciding with a clear: new capture wins, overflow stays 0
        drive(1'b1, 1'b0, 1'b0, 32'h0000_F000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_F000, 32'h0, 5'b00000, 5'b00000, 1'b1);
        exp_resp(5'b00000, 1'b1, 1'b1, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b1);
        exp_err(1'b1, 1'b0, 2'b01, 32'h0000_F000);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b0, 1'b0, 2'b01, 32'h0000_F000);
        cyc();

        // Slot 2 ready on the last allowed wait, twice back-to-back
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 5'b00000, 5'b00000, 1'b0);
            sb_push(S_PSELS, 64'(5'b00100));
            cyc();
            for (int k = 0; k < TO - 1; k++) begin
                drive(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 5'b00000, 5'b00000, 1'b0);
                sb_push(S_PREADY, 64'(1'b0));
                cyc();
            end
            drive(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 5'b00100, 5'b00000, 1'b0);
            exp_resp(5'b00100, 1'b1, 1'b0, rd[2]);
            cyc();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b0, 1'b0, 2'b01, 32'h0000_F000);
        cyc();

        // Make an error pending, then reset asynchronously mid-ACCESS
        drive(1'b1, 1'b0, 1'b0, 32'h0000_8000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b1, 1'b0, 2'b01, 32'h0000_8000);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 5'b00000, 5'b00000, 1'b0);
        #2;
        PRESETN = 1'b0;
        exp_resp(5'b00000, 1'b1, 1'b0, 32'h0);
        exp_err(1'b0, 1'b0, 2'b00, 32'h0);
        cyc();
        PRESETN = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        cyc();

        // First transfer after reset behaves normally
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 5'b00001, 5'b00000, 1'b0);
        sb_push(S_PSELS, 64'(5'b00001));
        cyc();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 5'b00001, 5'b00000, 1'b0);
        exp_resp(5'b00001, 1'b1, 1'b0, rd[0]);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'b00000, 5'b00000, 1'b0);
        exp_err(1'b0, 1'b0, 2'b00, 32'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
